gmii_speed_ctrl: RTL

- Link/speed supervisor for the GMII PHY interface.
- Periodically reads a PHY status register through an external MDIO master command/response handshake and decodes link and speed.
- Drives the interface's mii_select, holds the MAC-side datapath in reset while the link is down, and sequences speed changes as quiesce -> drain -> hold reset -> switch -> release.
- Sits beside the GMII PHY interface and the MDIO master in the same clock domain.

---
 rtl/gmii_speed_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/gmii_speed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gmii_speed_ctrl
// Function : Polls a PHY status register over MDIO and sequences GMII/MII
//            link and speed changes (quiesce, drain, hold reset, release).
// Revision : 1.0 - initial release
// ============================================================================
module gmii_speed_ctrl #(
  parameter logic [4:0]  PHY_ADDR      = 5'd0,
  parameter logic [4:0]  STAT_REG      = 5'd17,
  parameter int unsigned SPEED_LSB     = 14,
  parameter int unsigned LINK_BIT      = 10,
  parameter int unsigned POLL_PERIOD   = 1000000,
  parameter int unsigned RESP_TIMEOUT  = 4096,
  parameter int unsigned DRAIN_TIMEOUT = 8192,
  parameter int unsigned HOLD_CYCLES   = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [4:0]  cmd_phy_addr,
  output logic [4:0]  cmd_reg_addr,
  output logic [1:0]  cmd_opcode,
  input  logic        resp_valid,
  input  logic [15:0] resp_data,
  input  logic        tx_idle,
  output logic        tx_quiesce,
  output logic        mac_rst,
  output logic        mii_select,
  output logic        link_up,
  output logic [1:0]  speed,
  output logic [7:0]  err_count
);

  localparam logic [31:0] c_POLL_LAST  = 32'(POLL_PERIOD - 1);
  localparam logic [31:0] c_RESP_LAST  = 32'(RESP_TIMEOUT - 1);
  localparam logic [31:0] c_DRAIN_LAST = 32'(DRAIN_TIMEOUT - 1);
  localparam logic [31:0] c_HOLD_LAST  = 32'(HOLD_CYCLES - 1);
  localparam logic [1:0]  c_SPD_1000   = 2'b10;
  localparam logic [1:0]  c_SPD_RSVD   = 2'b11;

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_ISSUE = 3'd1,
    S_RESP  = 3'd2,
    S_EVAL  = 3'd3,
    S_DRAIN = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

  state_t      r_state;
  logic [31:0] r_timer;
  logic [31:0] r_cnt;
  logic        r_lnk;
  logic [1:0]  r_spd;
  logic        w_unused;

  assign cmd_phy_addr = PHY_ADDR;
  assign cmd_reg_addr = STAT_REG;
  assign cmd_opcode   = 2'b10;
  assign w_unused     = ^resp_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_WAIT;
      r_timer    <= c_POLL_LAST;
      r_cnt      <= '0;
      r_lnk      <= 1'b0;
      r_spd      <= c_SPD_1000;
      cmd_valid  <= 1'b0;
      tx_quiesce <= 1'b0;
      mac_rst    <= 1'b1;
      link_up    <= 1'b0;
      speed      <= c_SPD_1000;
      mii_select <= 1'b0;
      err_count  <= '0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_timer == '0) begin
            r_timer   <= c_POLL_LAST;
            cmd_valid <= 1'b1;
            r_state   <= S_ISSUE;
          end else begin
            r_timer <= r_timer - 32'd1;
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_valid) begin
            r_lnk   <= resp_data[LINK_BIT];
            r_spd   <= resp_data[SPEED_LSB +: 2];
            r_state <= S_EVAL;
          end else if (r_cnt == c_RESP_LAST) begin
            link_up <= 1'b0;
            mac_rst <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_EVAL: begin
          if (!r_lnk) begin
            link_up <= 1'b0;
            mac_rst <= 1'b1;
            r_state <= S_WAIT;
          end else if (r_spd == c_SPD_RSVD) begin
            r_state <= S_WAIT;
          end else if (!link_up) begin
            // MAC already held in reset, so skip the drain step
            speed      <= r_spd;
            mii_select <= (r_spd != c_SPD_1000);
            r_cnt      <= c_HOLD_LAST;
            r_state    <= S_HOLD;
          end else if (r_spd == speed) begin
            r_state <= S_WAIT;
          end else begin
            tx_quiesce <= 1'b1;
            r_cnt      <= '0;
            r_state    <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (tx_idle || (r_cnt == c_DRAIN_LAST)) begin
            if (!tx_idle && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
            speed      <= r_spd;
            mii_select <= (r_spd != c_SPD_1000);
            mac_rst    <= 1'b1;
            r_cnt      <= c_HOLD_LAST;
            r_state    <= S_HOLD;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_HOLD: begin
          if (r_cnt == '0) begin
            link_up    <= 1'b1;
            tx_quiesce <= 1'b0;
            mac_rst    <= 1'b0;
            r_state    <= S_WAIT;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        default: r_state <= S_WAIT;
      endcase
    end
  end

endmodule
`default_nettype wire
